// File: rtl/cpu_mem_if.sv
// cpu_mem_if: merges instruction fetch and data load/store onto one 16-bit bank; CPU_MEM_IF_FAIR_ARB_EN enables anti-starvation arbitration
module cpu_mem_if #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RSTb,
  input  logic [AW-1:0] instruction_memory_address,
  input  logic          instruction_memory_read_req,
  output logic [DW-1:0] instruction_memory_data,
  output logic [AW-1:0] instruction_memory_requested_address,
  output logic          instruction_memory_success,
  input  logic [AW-1:0] data_memory_address,
  input  logic [DW-1:0] data_memory_in,
  input  logic          data_memory_read_req,
  input  logic          data_memory_write_req,
  input  logic [1:0]    data_memory_wr_mask,
  output logic [DW-1:0] data_memory_data_out,
  output logic          data_memory_success,
  output logic          data_memory_was_requested,
  output logic [1:0]    data_memory_wr_mask_out,
  output logic          bank_sw,
  output logic [AW-1:0] memory_address,
  output logic [DW-1:0] data_out,
  input  logic [DW-1:0] data_in,
  output logic [1:0]    wr_mask,
  output logic          mem_wr,
  output logic          valid,
  input  logic          rdy
);
  logic          req_d, i_win, d_st, d_ld;
  logic          t_i, t_ld, t_st;
  logic [1:0]    t_mask;
  logic [AW-1:0] t_ia;
  assign req_d   = data_memory_read_req | data_memory_write_req;
  assign valid   = RSTb & (instruction_memory_read_req | req_d);
  assign bank_sw = valid & !rdy;
`ifdef CPU_MEM_IF_FAIR_ARB_EN
  logic [2:0] streak;
  assign i_win = instruction_memory_read_req & (!req_d | streak == 3'd4);
  // count granted cycles where data beat a pending fetch
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) streak <= 3'd0;
    else if (rdy) streak <= (!instruction_memory_read_req || i_win) ? 3'd0 : streak + 3'd1;
`else
  assign i_win = instruction_memory_read_req & !req_d;
`endif
  assign d_st = data_memory_write_req & !i_win;
  assign d_ld = data_memory_read_req & !data_memory_write_req & !i_win;
  // stage 0: drive the bank with the winner and tag the slot; ungranted slots carry a void tag
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      memory_address <= '0;
      data_out       <= '0;
      wr_mask        <= 2'b00;
      mem_wr         <= 1'b0;
      t_i            <= 1'b0;
      t_ld           <= 1'b0;
      t_st           <= 1'b0;
      t_mask         <= 2'b00;
      t_ia           <= '0;
    end else begin
      mem_wr <= rdy & d_st;
      t_i    <= rdy & i_win;
      t_ld   <= rdy & d_ld;
      t_st   <= rdy & d_st;
      t_mask <= (rdy & (d_st | d_ld)) ? data_memory_wr_mask : 2'b00;
      t_ia   <= instruction_memory_address;
      if (rdy & valid) begin
        memory_address <= i_win ? instruction_memory_address : data_memory_address;
        data_out       <= data_memory_in;
        wr_mask        <= i_win ? 2'b00 : data_memory_wr_mask;
      end
    end
  // stage 1: capture bank read data and retire the slot tag to the outputs
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      instruction_memory_data              <= '0;
      instruction_memory_requested_address <= '0;
      instruction_memory_success           <= 1'b0;
      data_memory_data_out                 <= '0;
      data_memory_success                  <= 1'b0;
      data_memory_was_requested            <= 1'b0;
      data_memory_wr_mask_out              <= 2'b00;
    end else begin
      instruction_memory_data              <= data_in;
      instruction_memory_requested_address <= t_ia;
      instruction_memory_success           <= t_i;
      data_memory_data_out                 <= data_in;
      data_memory_success                  <= t_ld | t_st;
      data_memory_was_requested            <= t_ld;
      data_memory_wr_mask_out              <= t_mask;
    end
endmodule

// File: tb/tb_cpu_mem_if.sv
// tb_cpu_mem_if: randomized scoreboard bench for cpu_mem_if with arbiter and bank models
module tb_cpu_mem_if;
  logic        CLK = 0, RSTb = 0;
  logic [14:0] ia = 0, da = 0;
  logic        ir = 0, drd = 0, dwr = 0, hold = 0;
  logic [15:0] di = 0;
  logic [1:0]  m = 0;
  logic [15:0] im_data, dm_out, data_out, data_in;
  logic [14:0] im_raddr, memory_address;
  logic        im_succ, dm_succ, was, bank_sw, mem_wr, valid, rdy, act;
  logic [1:0]  mask_out, wr_mask;
  int          total = 0, passed = 0;
  logic [15:0] bmem [0:32767];
  logic [15:0] rmem [0:32767];
  typedef struct packed {
    logic isucc; logic [14:0] ia; logic [15:0] idata;
    logic dsucc; logic was; logic [1:0] mk; logic [15:0] ddata;
  } slot_t;
  slot_t q[$];
  logic  exp_mw;
  logic [15:0] exp_do;
  logic [1:0]  exp_wm;
  int          streak;

  cpu_mem_if dut (
    .CLK(CLK), .RSTb(RSTb),
    .instruction_memory_address(ia), .instruction_memory_read_req(ir),
    .instruction_memory_data(im_data), .instruction_memory_requested_address(im_raddr),
    .instruction_memory_success(im_succ),
    .data_memory_address(da), .data_memory_in(di), .data_memory_read_req(drd),
    .data_memory_write_req(dwr), .data_memory_wr_mask(m), .data_memory_data_out(dm_out),
    .data_memory_success(dm_succ), .data_memory_was_requested(was),
    .data_memory_wr_mask_out(mask_out), .bank_sw(bank_sw), .memory_address(memory_address),
    .data_out(data_out), .data_in(data_in), .wr_mask(wr_mask), .mem_wr(mem_wr),
    .valid(valid), .rdy(rdy)
  );

  always #5 CLK = ~CLK;

  assign data_in = act ? bmem[memory_address] : 16'hBEEF;

  // arbiter grants the edge after valid; bank commits byte-masked writes
  always @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      rdy <= 0;
      act <= 0;
    end else begin
      rdy <= valid & !hold;
      act <= valid & rdy;
      if (mem_wr && wr_mask[1]) bmem[memory_address][15:8] <= data_out[15:8];
      if (mem_wr && wr_mask[0]) bmem[memory_address][7:0] <= data_out[7:0];
    end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  // reference model: decide each cycle's slot from the arbitration rules
  always @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      q.delete();
      exp_mw = 0;
      streak = 0;
    end else begin
      slot_t s;
      logic iw;
      s = '0;
      s.ia = ia;
      exp_mw = 0;
      iw = ir && !(drd || dwr);
`ifdef CPU_MEM_IF_FAIR_ARB_EN
      if (ir && (drd || dwr) && streak >= 4) iw = 1;
`endif
      if (rdy) begin
        if (iw) begin
          s.isucc = 1;
          s.idata = rmem[ia];
        end else if (dwr) begin
          s.dsucc = 1;
          s.mk = m;
          exp_mw = 1;
          exp_do = di;
          exp_wm = m;
          if (m[1]) rmem[da][15:8] = di[15:8];
          if (m[0]) rmem[da][7:0] = di[7:0];
        end else if (drd) begin
          s.dsucc = 1;
          s.was = 1;
          s.mk = m;
          s.ddata = rmem[da];
        end
        streak = (ir && !iw) ? streak + 1 : 0;
      end
      q.push_back(s);
    end

  // monitor: compare handshake every cycle and each output slot once it retires
  always @(negedge CLK)
    if (RSTb) begin
      chk("valid", valid, ir | drd | dwr);
      chk("bank_sw", bank_sw, (ir | drd | dwr) & !rdy);
      chk("mem_wr", mem_wr, exp_mw);
      if (exp_mw) begin
        chk("data_out", data_out, exp_do);
        chk("wr_mask", wr_mask, exp_wm);
      end
      if (q.size() >= 2) begin
        slot_t e;
        e = q.pop_front();
        chk("i_success", im_succ, e.isucc);
        chk("i_req_addr", im_raddr, e.ia);
        if (e.isucc) chk("i_data", im_data, e.idata);
        chk("d_success", dm_succ, e.dsucc);
        chk("d_was_req", was, e.was);
        chk("d_mask_out", mask_out, e.mk);
        if (e.was) chk("d_data", dm_out, e.ddata);
      end
    end

  task automatic drv(input logic i, input logic [14:0] a, input logic r, input logic w,
                     input logic [14:0] b, input logic [15:0] d, input logic [1:0] k, input logic h);
    @(posedge CLK);
    #2;
    ir = i; ia = a; drd = r; dwr = w; da = b; di = d; m = k; hold = h;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_flags"}, {im_succ, dm_succ, was, mem_wr, valid, bank_sw, mask_out, wr_mask}, 0);
    chk({n, "_data"}, {im_data, dm_out, data_out}, 0);
    chk({n, "_addr"}, {im_raddr, memory_address}, 0);
  endtask

  function automatic logic [14:0] pa();
    int s;
    s = $urandom_range(0, 5);
    return s == 0 ? 15'h0000 : s == 1 ? 15'h0001 : s == 2 ? 15'h0010 :
           s == 3 ? 15'h4000 : s == 4 ? 15'h7FFF : 15'($urandom);
  endfunction

  initial begin
    for (int a = 0; a < 32768; a++) begin
      bmem[a] = 16'(a) ^ 16'h5A5A;
      rmem[a] = 16'(a) ^ 16'h5A5A;
    end
    bmem[0] = 16'h1234; rmem[0] = 16'h1234;
    bmem[1] = 16'h5678; rmem[1] = 16'h5678;
    bmem[15'h4000] = 16'hCAFE; rmem[15'h4000] = 16'hCAFE;
    #3;
    chk_zero("reset");
    @(posedge CLK);
    @(posedge CLK);
    #2 RSTb = 1;
    idle(2);
    for (int c = 0; c < 3; c++) drv(1, 15'h0000, 0, 0, 0, 0, 0, 0);
    idle(3);
    drv(1, 15'h0000, 0, 0, 0, 0, 0, 0);
    drv(1, 15'h0001, 0, 0, 0, 0, 0, 0);
    drv(1, 15'h4000, 0, 0, 0, 0, 0, 0);
    drv(1, 15'h7FFF, 0, 0, 0, 0, 0, 0);
    drv(1, 15'h0000, 0, 0, 0, 0, 0, 0);
    idle(3);
    drv(0, 0, 0, 1, 15'h0010, 16'hA5A5, 2'b11, 0);
    drv(0, 0, 1, 0, 15'h0010, 0, 2'b11, 0);
    drv(0, 0, 0, 1, 15'h0010, 16'h1100, 2'b10, 0);
    drv(0, 0, 1, 0, 15'h0010, 0, 2'b01, 0);
    idle(3);
    drv(1, 15'h0001, 1, 0, 15'h0000, 0, 2'b11, 0);
    drv(1, 15'h0001, 1, 0, 15'h0000, 0, 2'b11, 0);
    drv(1, 15'h0001, 0, 0, 0, 0, 0, 0);
    drv(1, 15'h0001, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int c = 0; c < 3; c++) drv(1, 15'h0001, 1, 0, 15'h4000, 0, 2'b11, 1);
    for (int c = 0; c < 3; c++) drv(1, 15'h0001, 1, 0, 15'h4000, 0, 2'b11, 0);
    idle(3);
    for (int c = 0; c < 10; c++) drv(1, 15'h4000, 1, 0, 15'h0001, 0, 2'b11, 0);
    idle(3);
    drv(1, 15'h0001, 1, 0, 15'h0000, 0, 2'b11, 0);
    drv(1, 15'h0001, 1, 0, 15'h0000, 0, 2'b11, 0);
    #1 RSTb = 0;
    #1 chk_zero("midreset");
    @(posedge CLK);
    #2 RSTb = 1;
    idle(4);
    for (int c = 0; c < 3000; c++)
      drv($urandom_range(0, 2) != 0, pa(), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          pa(), 16'($urandom), 2'($urandom), $urandom_range(0, 7) == 0);
    idle(6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
